mnist_frame_downsampler: RTL

Converts the live OV7670 RGB565 pixel stream into the 28x28 8-bit grayscale image consumed by the MNIST accelerator. It sits between camera capture, which supplies the pixel stream, and the accelerator `top`, which reads pixels by index. On each software capture request it crops a centred 448x448 window, box-averages it in 16x16 blocks, and stores the 784 results in an internal buffer.

---
 rtl/mnist_frame_downsampler_if.sv | 43 ++++
 rtl/mnist_frame_downsampler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_downsampler_if.sv
//------------------------------------------------------------------------------
// mnist_frame_downsampler_if
//
// Bundles the pixel-stream, capture-control and image-read signals of
// mnist_frame_downsampler. The clock and reset stay plain ports on the
// modules that use this interface.
//
//   pix_valid      pixel stream qualifier
//   pix_sof        first pixel (0,0) of a frame, qualified by pix_valid
//   pix_data       RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   capture_req    single-cycle request to capture the next frame
//   busy           capture in progress
//   done           buffer holds a complete image
//   frame_err_cnt  saturating count of aborted captures
//   rd_addr        image index, row-major (by*OUT_DIM+bx)
//   rd_data        pixel at rd_addr, one cycle later
//
// Modports:
//   master  - stream source / software side (drives pixels, requests, reads)
//   slave   - the downsampler itself
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface mnist_frame_downsampler_if;
  logic        pix_valid;
  logic        pix_sof;
  logic [15:0] pix_data;
  logic        capture_req;
  logic        busy;
  logic        done;
  logic [7:0]  frame_err_cnt;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;

  modport master (
    output pix_valid, pix_sof, pix_data, capture_req, rd_addr,
    input  busy, done, frame_err_cnt, rd_data
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data, capture_req, rd_addr,
    output busy, done, frame_err_cnt, rd_data
  );
endinterface

// File: rtl/mnist_frame_downsampler.sv
//------------------------------------------------------------------------------
// mnist_frame_downsampler
//
// Turns the live RGB565 camera stream into the OUT_DIMxOUT_DIM 8-bit gray
// image read by the MNIST accelerator. On a capture request it waits for the
// next start of frame, crops a (OUT_DIM*16)-square window at
// (CROP_X0,CROP_Y0), box-averages 16x16 blocks and stores the results.
//
// Ports:
//   clk    system clock (pixel stream already synchronous to it)
//   reset  synchronous, active-high
//   bus    mnist_frame_downsampler_if.slave (stream, control, read port)
//
// Pipeline: stage 0 converts to gray and locates the pixel, stage 1 registers
// gray/lx/ly/in-crop, stage 2 accumulates and registers the memory write.
// A pixel accepted in cycle N is written to memory in cycle N+2.
//
// Build option: define DS_INVERT_EN to store 255-avg (white-on-black digits
// from dark ink on white paper); otherwise avg is stored.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module mnist_frame_downsampler #(
  parameter int SRC_W   = 640,
  parameter int SRC_H   = 480,
  parameter int CROP_X0 = 96,
  parameter int CROP_Y0 = 16,
  parameter int OUT_DIM = 28
) (
  input logic                      clk,
  input logic                      reset,
  mnist_frame_downsampler_if.slave bus
);

  localparam int CROP = OUT_DIM * 16;
  localparam int NPIX = OUT_DIM * OUT_DIM;
  localparam int AW   = $clog2(NPIX);
  localparam int BW   = $clog2(OUT_DIM);
  localparam int LW   = BW + 4;
  localparam logic [10:0]   NPIX_L    = 11'(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [11:0] x_q, x_d, y_q, y_d;
  logic [11:0] cur_x, cur_y;
  logic        in_crop, sof_v, accept, clear_acc, last_wr;
  logic [7:0]  r8, g8, b8, gray;
  logic [15:0] gray_sum;

  logic          s1_valid_q, s1_valid_d;
  logic [7:0]    s1_gray_q, s1_gray_d;
  logic [LW-1:0] s1_lx_q, s1_lx_d, s1_ly_q, s1_ly_d;

  logic [15:0]   acc_q [OUT_DIM];
  logic [15:0]   acc_d [OUT_DIM];
  logic [BW-1:0] bx, by;
  logic [15:0]   acc_sum;
  logic [7:0]    avg;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic       busy_q, busy_d, done_q, done_d;
  logic [7:0] err_q, err_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic [7:0] mem [NPIX];

  // Stage 0: frame position of the incoming pixel, counter advance, gray value.
  always_comb begin
    cur_x = bus.pix_sof ? 12'd0 : x_q;
    cur_y = bus.pix_sof ? 12'd0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (bus.pix_valid) begin
      if (cur_x == 12'(SRC_W - 1)) begin
        x_d = 12'd0;
        y_d = (cur_y == 12'(SRC_H - 1)) ? 12'd0 : cur_y + 12'd1;
      end else begin
        x_d = cur_x + 12'd1;
        y_d = cur_y;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    in_crop = (cur_x >= 12'(CROP_X0)) && (cur_x < 12'(CROP_X0 + CROP)) &&
              (cur_y >= 12'(CROP_Y0)) && (cur_y < 12'(CROP_Y0 + CROP));
    // Channel expansion replicates the MSBs so full scale maps to 255.
    r8       = {bus.pix_data[15:11], bus.pix_data[15:13]};
    g8       = {bus.pix_data[10:5],  bus.pix_data[10:9]};
    b8       = {bus.pix_data[4:0],   bus.pix_data[4:2]};
    gray_sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    gray     = 8'(gray_sum >> 8);
  end

  // Capture FSM next state; a completing write beats a simultaneous restart.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    clear_acc = 1'b0;
    err_d     = err_q;
    sof_v     = bus.pix_valid & bus.pix_sof;
    last_wr   = wr_en_q && (wr_addr_q == LAST_ADDR);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.capture_req) begin
          state_d   = ST_WAIT_SOF;
          clear_acc = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_SOF: begin
        if (sof_v) begin
          state_d = ST_CAPTURE;
          accept  = 1'b1;
        end else begin
          state_d = ST_WAIT_SOF;
        end
      end
      ST_CAPTURE: begin
        if (last_wr) begin
          state_d = ST_DONE;
        end else if (sof_v) begin
          // Frame restarted under us: drop partial sums, count the abort,
          // and treat this pixel as (0,0) of the new frame.
          clear_acc = 1'b1;
          accept    = 1'b1;
          err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end else begin
          accept = bus.pix_valid;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_WAIT_SOF) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // Stage 1 inputs: only accepted in-crop pixels travel down the pipe.
  always_comb begin
    s1_valid_d = accept && in_crop;
    s1_gray_d  = gray;
    s1_lx_d    = LW'(cur_x - 12'(CROP_X0));
    s1_ly_d    = LW'(cur_y - 12'(CROP_Y0));
  end

  // Stage 2: column accumulators and block write-back on the block's last pixel.
  always_comb begin
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bx        = s1_lx_q[LW-1:4];
    by        = s1_ly_q[LW-1:4];
    acc_sum   = acc_q[bx] + {8'd0, s1_gray_q};
    avg       = 8'(acc_sum >> 8);
    if (clear_acc) begin
      for (int i = 0; i < OUT_DIM; i++) acc_d[i] = 16'd0;
    end else if (s1_valid_q) begin
      if ((s1_lx_q[3:0] == 4'hF) && (s1_ly_q[3:0] == 4'hF)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = AW'(int'(by) * OUT_DIM + int'(bx));
`ifdef DS_INVERT_EN
        wr_data_d = 8'd255 - avg;
`else
        wr_data_d = avg;
`endif
        acc_d[bx] = 16'd0;
      end else begin
        acc_d[bx] = acc_sum;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Read port: out-of-range indices read as zero.
  always_comb begin
    if ({1'b0, bus.rd_addr} < NPIX_L) begin
      rd_data_d = mem[bus.rd_addr[AW-1:0]];
    end else begin
      rd_data_d = 8'd0;
    end
  end

  // Control registers: FSM state, counters, status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Pipeline registers: stage 1 pixel and stage 2 write request.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_gray_q  <= 8'd0;
      s1_lx_q    <= '0;
      s1_ly_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_gray_q  <= s1_gray_d;
      s1_lx_q    <= s1_lx_d;
      s1_ly_q    <= s1_ly_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Block-column accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= 16'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Image buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  // Registered read data; a same-cycle write is not forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= 8'd0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.frame_err_cnt = err_q;
  assign bus.rd_data       = rd_data_q;

endmodule
